// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : round-robin arbiter sharing one single-port data RAM among
//                NCORES cores, merging same-address reads into one RAM access.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int NCORES = 3,
    parameter int AW     = 8,
    parameter int DW     = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    wr,
    input  logic [NCORES*AW-1:0] Address,
    input  logic [NCORES*DW-1:0] Din,
    output logic [NCORES-1:0]    acq,
    output logic [DW-1:0]        Dq,
    input  logic [DW-1:0]        RAMq,
    output logic [AW-1:0]        RAMAddress,
    output logic [DW-1:0]        RAMDin,
    output logic                 RAMwren
);

    localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [PW-1:0]     g_q, g_d;
    logic              wr_q, wr_d;
    logic [NCORES-1:0] mask_q, mask_d;
    logic [NCORES-1:0] acq_q, acq_d;
    logic [DW-1:0]     dq_q, dq_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     din_q, din_d;
    logic              wren_q, wren_d;

    logic              win_found;
    logic [PW-1:0]     win;
    logic              win_wr;
    logic [AW-1:0]     win_addr;
    logic [DW-1:0]     win_din;
    logic [NCORES-1:0] win_mask;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
        int s;
        s = (int'(p) + k) % NCORES;
        return PW'(s);
    endfunction

    // Search starts just after the last served core, so it gets lowest priority.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        for (int k = 1; k <= NCORES; k++) begin
            if (!win_found && req[rr_idx(rr_q, k)]) begin
                win_found = 1'b1;
                win       = rr_idx(rr_q, k);
            end
        end
        win_wr   = wr[win];
        win_addr = Address[int'(win)*AW +: AW];
        win_din  = Din[int'(win)*DW +: DW];
    end

    // Only reads by other cores ride along on a read winner; writes never merge.
    always_comb begin
        win_mask = '0;
        for (int j = 0; j < NCORES; j++) begin
            win_mask[j] = (j == int'(win)) ||
                          (!win_wr && req[j] && !wr[j] &&
                           (Address[j*AW +: AW] == win_addr));
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        g_d     = g_q;
        wr_d    = wr_q;
        mask_d  = mask_q;
        acq_d   = '0;
        dq_d    = dq_q;
        addr_d  = addr_q;
        din_d   = din_q;
        wren_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    addr_d  = win_addr;
                    din_d   = win_din;
                    wren_d  = win_wr;
                    g_d     = win;
                    wr_d    = win_wr;
                    mask_d  = win_mask;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wr_q) begin
                    acq_d   = mask_q;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                dq_d    = RAMq;
                acq_d   = mask_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                rr_d    = g_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            rr_q    <= PW'(NCORES - 1);
            g_q     <= '0;
            wr_q    <= 1'b0;
            mask_q  <= '0;
            acq_q   <= '0;
            dq_q    <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            g_q     <= g_d;
            wr_q    <= wr_d;
            mask_q  <= mask_d;
            acq_q   <= acq_d;
            dq_q    <= dq_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wren_q  <= wren_d;
        end
    end

    assign acq        = acq_q;
    assign Dq         = dq_q;
    assign RAMAddress = addr_q;
    assign RAMDin     = din_q;
    assign RAMwren    = wren_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : scoreboard bench for dmem_arbiter with a behavioural RAM.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int NC = 3;
    localparam int AW = 8;
    localparam int DW = 8;

    logic              clk  = 1'b0;
    logic              rstn = 1'b0;
    logic [NC-1:0]     req  = '0;
    logic [NC-1:0]     wr   = '0;
    logic [NC*AW-1:0]  Address = '0;
    logic [NC*DW-1:0]  Din  = '0;
    logic [NC-1:0]     acq;
    logic [DW-1:0]     Dq;
    logic [DW-1:0]     RAMq = '0;
    logic [AW-1:0]     RAMAddress;
    logic [DW-1:0]     RAMDin;
    logic              RAMwren;

    dmem_arbiter #(.NCORES(NC), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rstn(rstn), .req(req), .wr(wr), .Address(Address),
        .Din(Din), .acq(acq), .Dq(Dq), .RAMq(RAMq),
        .RAMAddress(RAMAddress), .RAMDin(RAMDin), .RAMwren(RAMwren)
    );

    always #5 clk = ~clk;

    // RAM preloaded with mem[a] = ~a, except mem[0x10] = 0x5A.
    logic [DW-1:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = ~i[7:0];
        mem[8'h10] = 8'h5A;
    end
    always @(posedge clk) begin
        if (RAMwren) mem[RAMAddress] <= RAMDin;
        RAMq <= mem[RAMAddress];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit w; logic [7:0] a; logic [7:0] d; } op_t;
    typedef struct { logic [NC-1:0] acq; bit chk_dq; logic [7:0] dq; int lat; } exp_t;
    typedef struct { logic [7:0] a; logic [7:0] d; int core; int lat; } wexp_t;

    op_t   opq [NC][$];
    exp_t  expq[$];
    wexp_t wq[$];
    int    start_cyc [NC];
    logic [NC-1:0] acq_s = '0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Core agents: hold an op until its acq is seen, then drop or load the next.
    always @(negedge clk) acq_s = acq;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NC; i++) begin
                if (req[i] && acq_s[i]) begin
                    void'(opq[i].pop_front());
                    req[i] = 1'b0;
                end
                if (!req[i] && opq[i].size() > 0) begin
                    wr[i]            = opq[i][0].w;
                    Address[i*AW +: AW] = opq[i][0].a;
                    Din[i*DW +: DW]     = opq[i][0].d;
                    req[i]           = 1'b1;
                    start_cyc[i]     = cyc;
                end
            end
        end
    end

    // Monitor: pops expected completions and RAM writes as they appear.
    bit wren_prev = 1'b0;
    initial begin
        exp_t  e;
        wexp_t we;
        int    lc;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (acq != '0) begin
                    if (expq.size() == 0) begin
                        fail_now("unexpected_acq");
                    end else begin
                        e = expq.pop_front();
                        chk("acq", int'(acq), int'(e.acq));
                        if (e.chk_dq) chk("Dq", int'(Dq), int'(e.dq));
                        if (e.lat >= 0) begin
                            lc = 0;
                            for (int i = NC-1; i >= 0; i--) if (e.acq[i]) lc = i;
                            chk("acq_latency", cyc - start_cyc[lc], e.lat);
                        end
                    end
                end
                if (RAMwren) begin
                    if (wren_prev) fail_now("wren_longer_than_one_cycle");
                    if (wq.size() == 0) begin
                        fail_now("unexpected_wren");
                    end else begin
                        we = wq.pop_front();
                        chk("RAMAddress_wr", int'(RAMAddress), int'(we.a));
                        chk("RAMDin_wr", int'(RAMDin), int'(we.d));
                        if (we.lat >= 0) chk("wren_latency", cyc - start_cyc[we.core], we.lat);
                    end
                end
            end
            wren_prev = RAMwren;
        end
    end

    task automatic push_op(input int c, input bit w, input logic [7:0] a, input logic [7:0] d);
        op_t o;
        o.w = w; o.a = a; o.d = d;
        opq[c].push_back(o);
    endtask

    task automatic push_exp(input logic [NC-1:0] m, input bit cd, input logic [7:0] dq, input int lat);
        exp_t e;
        e.acq = m; e.chk_dq = cd; e.dq = dq; e.lat = lat;
        expq.push_back(e);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d, input int core, input int lat);
        wexp_t w;
        w.a = a; w.d = d; w.core = core; w.lat = lat;
        wq.push_back(w);
    endtask

    task automatic wait_idle(input string name);
        int  n;
        bit  busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
            busy = (req != '0) || (expq.size() != 0) || (wq.size() != 0);
            for (int i = 0; i < NC; i++) if (opq[i].size() != 0) busy = 1'b1;
        end
        if (busy) begin
            fail_now({"timeout_", name});
            expq.delete();
            wq.delete();
            for (int i = 0; i < NC; i++) opq[i].delete();
            req = '0;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_acq", int'(acq), 0);
        chk("rst_Dq", int'(Dq), 0);
        chk("rst_RAMAddress", int'(RAMAddress), 0);
        chk("rst_RAMDin", int'(RAMDin), 0);
        chk("rst_RAMwren", int'(RAMwren), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Single read
        push_exp(3'b010, 1'b1, 8'h5A, 3);
        push_op(1, 1'b0, 8'h10, 8'h00);
        wait_idle("single_read");

        // Single write, then read-back
        push_wr(8'h20, 8'hC3, 2, 1);
        push_exp(3'b100, 1'b0, 8'h00, 2);
        push_op(2, 1'b1, 8'h20, 8'hC3);
        wait_idle("single_write");
        push_exp(3'b100, 1'b1, 8'hC3, 3);
        push_op(2, 1'b0, 8'h20, 8'h00);
        wait_idle("readback");

        // Round-robin from pointer 2, core0 re-requests after its first acq
        push_exp(3'b001, 1'b1, 8'hFE, -1);
        push_exp(3'b010, 1'b1, 8'hFD, -1);
        push_exp(3'b100, 1'b1, 8'hFC, -1);
        push_exp(3'b001, 1'b1, 8'hFB, -1);
        push_op(0, 1'b0, 8'h01, 8'h00);
        push_op(0, 1'b0, 8'h04, 8'h00);
        push_op(1, 1'b0, 8'h02, 8'h00);
        push_op(2, 1'b0, 8'h03, 8'h00);
        wait_idle("round_robin");

        // Coalescing right after a reset
        @(negedge clk) rstn = 1'b0;
        @(negedge clk) rstn = 1'b1;
        push_exp(3'b101, 1'b1, 8'hCC, 3);
        push_exp(3'b010, 1'b1, 8'hCB, -1);
        push_op(0, 1'b0, 8'h33, 8'h00);
        push_op(1, 1'b0, 8'h34, 8'h00);
        push_op(2, 1'b0, 8'h33, 8'h00);
        wait_idle("coalesce");

        // Write winner never merges a same-address read
        push_wr(8'h40, 8'h77, 0, 1);
        push_exp(3'b001, 1'b0, 8'h00, 2);
        push_exp(3'b010, 1'b1, 8'h77, -1);
        push_op(0, 1'b1, 8'h40, 8'h77);
        push_op(1, 1'b0, 8'h40, 8'h00);
        wait_idle("no_write_merge");

        // Read winner never absorbs a pending same-address write
        push_exp(3'b100, 1'b1, 8'hAF, 3);
        push_exp(3'b001, 1'b0, 8'h00, -1);
        push_wr(8'h50, 8'h11, 0, -1);
        push_op(2, 1'b0, 8'h50, 8'h00);
        push_op(0, 1'b1, 8'h50, 8'h11);
        wait_idle("no_write_absorb");

        // Reset during WAIT of core2's read; afterwards core0 wins first
        push_exp(3'b001, 1'b1, 8'hFA, -1);
        push_exp(3'b100, 1'b1, 8'hF9, -1);
        push_op(0, 1'b0, 8'h05, 8'h00);
        push_op(2, 1'b0, 8'h06, 8'h00);
        n = 0;
        while (req == '0 && n < 20) begin @(negedge clk); n++; end
        if (req == '0) fail_now("reset_test_no_req");
        n = 0;
        while (cyc < start_cyc[2] + 2 && n < 20) begin @(negedge clk); n++; end
        rstn = 1'b0;
        #1;
        chk("midrst_acq", int'(acq), 0);
        chk("midrst_RAMwren", int'(RAMwren), 0);
        chk("midrst_Dq", int'(Dq), 0);
        chk("midrst_RAMAddress", int'(RAMAddress), 0);
        @(negedge clk) rstn = 1'b1;
        wait_idle("reset_in_wait");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
